// File: rtl/pad_alsaqr_bidir_ctrl.sv
// ---------------------------------------------------------------------------
// pad_alsaqr_bidir_ctrl
//
// Core-side controller for one bidirectional pad cell. It owns the pad's
// output enable (OEN, active-low drive) and output value (I), and it samples
// the pad's input (O).
//
// Direction changes always pass through a turnaround state. In that state
// OEN is held high for TURN_CYCLES cycles, so the pad and any external driver
// never drive the line at the same time.
//
// The incoming pad level is synchronized and then deglitched. The core
// receives a clean level and a one-cycle edge pulse.
//
// Ports
//   clk_i       clock
//   rst_i       synchronous reset, active-high
//   drv_req_i   core drive request (level, held for the whole transfer)
//   drv_data_i  value to drive while granted
//   drv_gnt_o   high while the pad is actually driven (state TX)
//   busy_o      high whenever the controller is not in RX
//   rx_data_o   filtered received level
//   rx_edge_o   one-cycle pulse in the cycle rx_data_o changes
//   pad_oen_o   pad OEN: 0 = drive, 1 = high-Z
//   pad_out_o   pad I (drive value)
//   pad_in_i    pad O, asynchronous to clk_i
//
// Request/grant handshake: drv_req_i is a level request that the core holds
// for as long as it wants the pad. drv_gnt_o rises once the turnaround has
// completed and the pad is driven. drv_data_i is then transferred to the pad
// every cycle with one cycle of latency. Dropping drv_req_i at any time ends
// the transfer. From TX this enters TURN_RX; during TURN_TX it aborts straight
// back to RX, because the pad was never driven. A request seen during TURN_RX
// is not lost. It is served through a fresh TURN_TX once RX has been reached.
// ---------------------------------------------------------------------------
module pad_alsaqr_bidir_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int TURN_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic drv_req_i,
  input  logic drv_data_i,
  output logic drv_gnt_o,
  output logic busy_o,
  output logic rx_data_o,
  output logic rx_edge_o,
  output logic pad_oen_o,
  output logic pad_out_o,
  input  logic pad_in_i
);

  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam int FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RX      = 2'd0,
    ST_TURN_TX = 2'd1,
    ST_TX      = 2'd2,
    ST_TURN_RX = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [TW-1:0]          turn_cnt;
  logic                   turn_done;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic [FW-1:0]          filt_cnt;
  logic                   rx_q;
  logic                   edge_q;
  logic                   oen_q;
  logic                   out_q;
  logic                   gnt_q;
  logic                   busy_q;

  assign turn_done = (turn_cnt == TURN_LAST);
  assign sync_lvl  = sync_q[SYNC_STAGES-1];

  // Next-state decode. In TURN_TX, a dropped request is checked before the
  // turnaround-complete condition. An abort on the boundary cycle therefore
  // returns to RX and never drives the pad.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RX: begin
        if (drv_req_i) state_nxt = ST_TURN_TX;
      end
      ST_TURN_TX: begin
        if (!drv_req_i)     state_nxt = ST_RX;
        else if (turn_done) state_nxt = ST_TX;
      end
      ST_TX: begin
        if (!drv_req_i) state_nxt = ST_TURN_RX;
      end
      ST_TURN_RX: begin
        // Fixed length regardless of drv_req_i, so the far side always
        // gets its full dead time.
        if (turn_done) state_nxt = ST_RX;
      end
      default: state_nxt = ST_RX;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_RX;
      turn_cnt <= '0;
      sync_q   <= '0;
      filt_cnt <= '0;
      rx_q     <= 1'b0;
      edge_q   <= 1'b0;
      oen_q    <= 1'b1;
      out_q    <= 1'b0;
      gnt_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state <= state_nxt;

      // The turnaround counter only runs while we stay in a turn state. Any
      // state change restarts it from zero.
      if (state_nxt != state) begin
        turn_cnt <= '0;
      end else if (state == ST_TURN_TX || state == ST_TURN_RX) begin
        turn_cnt <= turn_cnt + TW'(1);
      end else begin
        turn_cnt <= '0;
      end

      // The output registers are loaded from the next state, so each one
      // lines up exactly with the state it describes.
      oen_q  <= (state_nxt != ST_TX);
      gnt_q  <= (state_nxt == ST_TX);
      busy_q <= (state_nxt != ST_RX);
      out_q  <= (state_nxt == ST_TX) ? drv_data_i : 1'b0;

      // The synchronizer runs in every state.
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in_i};

      // The deglitch filter runs in RX only. Elsewhere it is held cleared, so
      // the echo of our own drive is ignored. On RX entry it starts from
      // zero, and any level difference present then still propagates after
      // FILT_CYCLES cycles.
      edge_q <= 1'b0;
      if (state == ST_RX) begin
        if (sync_lvl != rx_q) begin
          if (filt_cnt == FILT_LAST) begin
            rx_q     <= sync_lvl;
            edge_q   <= 1'b1;
            filt_cnt <= '0;
          end else begin
            filt_cnt <= filt_cnt + FW'(1);
          end
        end else begin
          filt_cnt <= '0;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign pad_oen_o = oen_q;
  assign pad_out_o = out_q;
  assign drv_gnt_o = gnt_q;
  assign busy_o    = busy_q;
  assign rx_data_o = rx_q;
  assign rx_edge_o = edge_q;

endmodule
